// File: rtl/cic_seq.sv
// Sequencer around a CIC decimator: clears the filter, discards settling outputs,
// generates the decimation tick and holds output samples under a valid/ready handshake.
// Optional build macro CIC_SEQ_STATS_EN adds the stat_out / stat_drop counters.
`default_nettype none

module cic_seq #(
  parameter int RATIO_W = 8,
  parameter int OUT_W   = 33,
  parameter int CLR_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RATIO_W-1:0]      cfg_ratio,
  input  logic [3:0]              cfg_settle,
  input  logic                    cfg_load,
  input  logic                    in_valid,
  input  logic                    cic_valid,
  input  logic signed [OUT_W-1:0] cic_data,
  output logic                    cic_clr,
  output logic                    cic_dec_tick,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  output logic                    cfg_err,
`ifdef CIC_SEQ_STATS_EN
  output logic [15:0]             stat_out,
  output logic [15:0]             stat_drop,
`endif
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [RATIO_W-1:0] RATIO_MIN = RATIO_W'(2);

  state_t               state;
  state_t               state_nxt;
  logic [CLR_W-1:0]     clr_cnt;
  logic [3:0]           settle_q;
  logic [3:0]           settle_cnt;
  logic [RATIO_W-1:0]   ratio_q;
  logic [RATIO_W-1:0]   phase;

  logic ratio_low;
  logic clr_done;
  logic settle_done;
  logic counting;
  logic phase_wrap;
  logic run_sample;
  logic drop;

  assign ratio_low   = (cfg_ratio < RATIO_MIN);
  assign clr_done    = (clr_cnt == CLR_W'(CLR_CYC - 1));
  // A zero settle count still spends one cycle in SETTLE.
  assign settle_done = (settle_q == 4'd0) ||
                       (cic_valid && (settle_cnt == settle_q - 4'd1));
  assign counting    = (state == SETTLE) || (state == RUN);
  assign phase_wrap  = (phase == ratio_q - RATIO_W'(1));
  assign run_sample  = (state == RUN) && cic_valid;
  assign drop        = run_sample && out_valid && !out_ready;

  assign cic_clr = (state == CLEAR);
  assign busy    = (state == CLEAR) || (state == SETTLE);

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = IDLE;
      CLEAR:   if (clr_done)    state_nxt = SETTLE;
      SETTLE:  if (settle_done) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (cfg_load) state_nxt = CLEAR;
  end

  // ---------------------------------------------------------------------------
  // Configuration latch and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ratio_q  <= RATIO_MIN;
      settle_q <= 4'd0;
      cfg_err  <= 1'b0;
    end else if (cfg_load) begin
      ratio_q  <= ratio_low ? RATIO_MIN : cfg_ratio;
      settle_q <= cfg_settle;
      cfg_err  <= ratio_low;
    end
  end

  // A cfg_load while already in CLEAR restarts the clear window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_cnt <= '0;
    end else if ((state == CLEAR) && !clr_done && !cfg_load) begin
      clr_cnt <= clr_cnt + CLR_W'(1);
    end else begin
      clr_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_cnt <= 4'd0;
    end else if (state != SETTLE) begin
      settle_cnt <= 4'd0;
    end else if (cic_valid) begin
      settle_cnt <= settle_cnt + 4'd1;
    end
  end

  // The tick is registered, so it lands in the cycle after the wrapping sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase        <= '0;
      cic_dec_tick <= 1'b0;
    end else begin
      cic_dec_tick <= counting && in_valid && phase_wrap;
      if (state == CLEAR) begin
        phase <= '0;
      end else if (counting && in_valid) begin
        phase <= phase_wrap ? '0 : phase + RATIO_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output holding register
  // ---------------------------------------------------------------------------
  // cfg_load has priority over a coincident sample, which is discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (cfg_load) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (drop) begin
      overrun   <= 1'b1;
    end else if (run_sample) begin
      out_data  <= cic_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CIC_SEQ_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating transfer / drop statistics
  // ---------------------------------------------------------------------------
  logic xfer;
  assign xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_out  <= 16'd0;
      stat_drop <= 16'd0;
    end else if (cfg_load) begin
      stat_out  <= 16'd0;
      stat_drop <= 16'd0;
    end else begin
      if (xfer && (stat_out != 16'hFFFF))  stat_out  <= stat_out + 16'd1;
      if (drop && (stat_drop != 16'hFFFF)) stat_drop <= stat_drop + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cic_seq.sv
// Self-checking bench for cic_seq: directed scenarios plus a randomized run
// scored against a transaction-level model of the sequencer.
`timescale 1ns/1ps

module tb_cic_seq;

  localparam int RATIO_W = 8;
  localparam int OUT_W   = 33;
  localparam int CLR_CYC = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [RATIO_W-1:0]      cfg_ratio = '0;
  logic [3:0]              cfg_settle = '0;
  logic                    cfg_load = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    cic_valid = 1'b0;
  logic signed [OUT_W-1:0] cic_data = '0;
  logic                    out_ready = 1'b0;
  logic                    cic_clr;
  logic                    cic_dec_tick;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    overrun;
  logic                    cfg_err;
  logic                    busy;
`ifdef CIC_SEQ_STATS_EN
  logic [15:0]             stat_out;
  logic [15:0]             stat_drop;
`endif

  int n_cmp = 0;
  int n_err = 0;

  cic_seq #(.RATIO_W(RATIO_W), .OUT_W(OUT_W), .CLR_CYC(CLR_CYC)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_ratio    (cfg_ratio),
    .cfg_settle   (cfg_settle),
    .cfg_load     (cfg_load),
    .in_valid     (in_valid),
    .cic_valid    (cic_valid),
    .cic_data     (cic_data),
    .cic_clr      (cic_clr),
    .cic_dec_tick (cic_dec_tick),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overrun      (overrun),
    .cfg_err      (cfg_err),
`ifdef CIC_SEQ_STATS_EN
    .stat_out     (stat_out),
    .stat_drop    (stat_drop),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Advance one clock; outputs are then read 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_load  = 1'b0;
    in_valid  = 1'b0;
    cic_valid = 1'b0;
    out_ready = 1'b0;
    cic_data  = '0;
  endtask

  task automatic do_load(input int ratio, input int settle);
    cfg_ratio  = RATIO_W'(ratio);
    cfg_settle = 4'(settle);
    cfg_load   = 1'b1;
    step();
    cfg_load   = 1'b0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 64 && busy; i++) step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL wait_run: busy=%b after 64 cycles, required 0", busy);
    end
  endtask

  // Drives in_valid for a number of cycles and records tick statistics.
  task automatic run_in_valid(input int cycles, output int count, output int first_at,
                              output int min_gap, output int max_gap);
    int last;
    count = 0; first_at = -1; min_gap = 1 << 30; max_gap = 0; last = -1;
    in_valid = 1'b1;
    for (int i = 1; i <= cycles; i++) begin
      step();
      if (cic_dec_tick === 1'b1) begin
        count++;
        if (last < 0) first_at = i;
        else begin
          if (i - last < min_gap) min_gap = i - last;
          if (i - last > max_gap) max_gap = i - last;
        end
        last = i;
      end
    end
    in_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    n_cmp++;
    if ({cic_clr, cic_dec_tick, out_valid, overrun, cfg_err, busy} !== 6'b0 || out_data !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: clr=%b tick=%b ov=%b ovr=%b err=%b busy=%b data=%0d, required all 0",
               cic_clr, cic_dec_tick, out_valid, overrun, cfg_err, busy, out_data);
    end
`ifdef CIC_SEQ_STATS_EN
    n_cmp++;
    if (stat_out !== 16'd0 || stat_drop !== 16'd0) begin
      n_err++;
      $display("FAIL reset_stats: out=%0d drop=%0d, required 0/0", stat_out, stat_drop);
    end
`endif
    rst = 1'b1;
    in_valid = 1'b1; cic_valid = 1'b1; cic_data = OUT_W'(5);
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++;
      if ({cic_clr, cic_dec_tick, out_valid, busy} !== 4'b0) begin
        n_err++;
        $display("FAIL reset_release_idle: clr=%b tick=%b ov=%b busy=%b, required 0",
                 cic_clr, cic_dec_tick, out_valid, busy);
      end
    end
    idle_inputs();
  endtask

  task automatic test_settle();
    int clr_cycles;
    idle_inputs();
    do_load(64, 3);
    clr_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      if (cic_clr === 1'b1) clr_cycles++;
      step();
    end
    n_cmp++;
    if (clr_cycles != CLR_CYC) begin
      n_err++;
      $display("FAIL clr_length: observed %0d cycles, required %0d", clr_cycles, CLR_CYC);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL settle_busy: busy=%b, required 1", busy);
    end
    for (int k = 1; k <= 3; k++) begin
      cic_valid = 1'b1; cic_data = OUT_W'(11 * k);
      step();
      cic_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL settle_discard_%0d: out_valid=%b, required 0", k, out_valid);
      end
      step();
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL settle_to_run: busy=%b, required 0", busy);
    end
    cic_valid = 1'b1; cic_data = -OUT_W'(44);
    step();
    cic_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== -OUT_W'(44)) begin
      n_err++;
      $display("FAIL first_sample: valid=%b data=%0d, required 1/-44", out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL transfer_clears_valid: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_tick();
    int cnt, first, mn, mx;
    idle_inputs();
    do_load(64, 0);
    wait_run();
    run_in_valid(640, cnt, first, mn, mx);
    n_cmp++;
    if (cnt != 640 / 64 || first != 64 || mn != 64 || mx != 64) begin
      n_err++;
      $display("FAIL tick_ratio64: count=%0d first=%0d gap=%0d..%0d, required 10/64/64..64",
               cnt, first, mn, mx);
    end
    step();
    n_cmp++;
    if (cic_dec_tick !== 1'b0) begin
      n_err++;
      $display("FAIL tick_one_cycle: tick=%b, required 0", cic_dec_tick);
    end
  endtask

  task automatic test_overrun();
    idle_inputs();
    do_load(8, 0);
    wait_run();
    cic_valid = 1'b1; cic_data = OUT_W'(300);
    step();
    cic_data = OUT_W'(400); out_ready = 1'b1;
    step();
    cic_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== OUT_W'(400) || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL load_on_accept: valid=%b data=%0d ovr=%b, required 1/400/0",
               out_valid, out_data, overrun);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    cic_valid = 1'b1; cic_data = OUT_W'(100);
    step();
    cic_data = OUT_W'(200);
    step();
    cic_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== OUT_W'(100) || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_hold: valid=%b data=%0d ovr=%b, required 1/100/1",
               out_valid, out_data, overrun);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_sticky: valid=%b ovr=%b, required 0/1", out_valid, overrun);
    end
`ifdef CIC_SEQ_STATS_EN
    n_cmp++;
    if (stat_out !== 16'd3 || stat_drop !== 16'd1) begin
      n_err++;
      $display("FAIL stats_counts: out=%0d drop=%0d, required 3/1", stat_out, stat_drop);
    end
`endif
  endtask

  task automatic test_ratio_err();
    int cnt, first, mn, mx;
    idle_inputs();
    do_load(1, 0);
    n_cmp++;
    if (cfg_err !== 1'b1 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ratio1_err: cfg_err=%b overrun=%b, required 1/0", cfg_err, overrun);
    end
    wait_run();
    run_in_valid(20, cnt, first, mn, mx);
    n_cmp++;
    if (cnt != 10 || first != 2 || mn != 2 || mx != 2) begin
      n_err++;
      $display("FAIL tick_ratio2: count=%0d first=%0d gap=%0d..%0d, required 10/2/2..2",
               cnt, first, mn, mx);
    end
    do_load(8, 0);
    n_cmp++;
    if (cfg_err !== 1'b0) begin
      n_err++;
      $display("FAIL ratio8_clears_err: cfg_err=%b, required 0", cfg_err);
    end
  endtask

  task automatic test_reset_mid_run();
    int cnt, first, mn, mx, busy_seen;
    idle_inputs();
    do_load(16, 0);
    wait_run();
    cic_valid = 1'b1; cic_data = OUT_W'(55);
    step();
    cic_valid = 1'b0; in_valid = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_run_setup: out_valid=%b, required 1", out_valid);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, busy, cic_clr, cic_dec_tick, overrun} !== 5'b0 || out_data !== '0) begin
      n_err++;
      $display("FAIL async_reset: ov=%b busy=%b clr=%b tick=%b ovr=%b data=%0d, required all 0",
               out_valid, busy, cic_clr, cic_dec_tick, overrun, out_data);
    end
    step();
    rst = 1'b1;
    busy_seen = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cic_dec_tick === 1'b1) cnt++;
      if (busy === 1'b1 || cic_clr === 1'b1) busy_seen++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (cnt != 0 || busy_seen != 0) begin
      n_err++;
      $display("FAIL idle_after_reset: ticks=%0d busy_cycles=%0d, required 0/0", cnt, busy_seen);
    end
    do_load(4, 0);
    wait_run();
    run_in_valid(8, cnt, first, mn, mx);
    n_cmp++;
    if (cnt != 2 || first != 4) begin
      n_err++;
      $display("FAIL restart_after_reset: count=%0d first=%0d, required 2/4", cnt, first);
    end
  endtask

  task automatic test_load_collision();
    idle_inputs();
    do_load(8, 0);
    wait_run();
    out_ready = 1'b1;
    cic_valid = 1'b1; cic_data = OUT_W'(77);
    cfg_load  = 1'b1;
    step();
    idle_inputs();
    n_cmp++;
    if (out_valid !== 1'b0 || cic_clr !== 1'b1) begin
      n_err++;
      $display("FAIL load_wins: out_valid=%b cic_clr=%b, required 0/1", out_valid, cic_clr);
    end
  endtask

  // Randomized run against a transaction-level model of the sequencer.
  task automatic test_random();
    int ratio_req, ratio_eff, settle, clear_left, settle_left, n_in;
    int m_xfer, m_drop;
    logic m_valid, m_ovr, m_tick, iv, cv, rdy;
    logic signed [OUT_W-1:0] m_data, d;
    for (int round = 0; round < 5; round++) begin
      idle_inputs();
      ratio_req = $urandom_range(0, 9);
      settle    = $urandom_range(1, 4);
      ratio_eff = (ratio_req < 2) ? 2 : ratio_req;
      do_load(ratio_req, settle);
      n_cmp++;
      if (cfg_err !== (ratio_req < 2)) begin
        n_err++;
        $display("FAIL rand_cfg_err r%0d: cfg_err=%b for ratio %0d", round, cfg_err, ratio_req);
      end
      clear_left = CLR_CYC; settle_left = settle; n_in = 0;
      m_valid = 1'b0; m_ovr = 1'b0; m_data = '0; m_xfer = 0; m_drop = 0;
      for (int c = 0; c < 160; c++) begin
        iv  = 1'($urandom_range(0, 1));
        cv  = ($urandom_range(0, 2) == 0);
        rdy = 1'($urandom_range(0, 1));
        d   = {1'($urandom_range(0, 1)), 32'($urandom)};
        in_valid = iv; cic_valid = cv; out_ready = rdy; cic_data = d;
        m_tick = 1'b0;
        if (clear_left > 0) begin
          clear_left--;
        end else begin
          if (iv) begin
            n_in++;
            m_tick = ((n_in % ratio_eff) == 0);
          end
          if (settle_left > 0) begin
            if (cv) settle_left--;
          end else if (cv) begin
            if (!m_valid || rdy) begin
              if (m_valid) m_xfer++;
              m_data = d; m_valid = 1'b1;
            end else begin
              m_ovr = 1'b1; m_drop++;
            end
          end else if (m_valid && rdy) begin
            m_valid = 1'b0; m_xfer++;
          end
        end
        step();
        n_cmp++;
        if (cic_dec_tick !== m_tick || out_valid !== m_valid || overrun !== m_ovr ||
            busy !== (clear_left > 0 || settle_left > 0) || cic_clr !== (clear_left > 0) ||
            (m_valid && out_data !== m_data)) begin
          n_err++;
          $display("FAIL rand r%0d c%0d: tick=%b/%b valid=%b/%b ovr=%b/%b busy=%b clr=%b data=%0d/%0d (got/required)",
                   round, c, cic_dec_tick, m_tick, out_valid, m_valid, overrun, m_ovr,
                   busy, cic_clr, out_data, m_data);
        end
`ifdef CIC_SEQ_STATS_EN
        n_cmp++;
        if (stat_out !== 16'(m_xfer) || stat_drop !== 16'(m_drop)) begin
          n_err++;
          $display("FAIL rand_stats r%0d c%0d: out=%0d drop=%0d, required %0d/%0d",
                   round, c, stat_out, stat_drop, m_xfer, m_drop);
        end
`endif
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_settle();
    test_tick();
    test_overrun();
    test_ratio_err();
    test_reset_mid_run();
    test_load_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cic_seq.md
CIC_SEQ -- requirements
Module: cic_seq

Interface
REQ-001 The block SHALL have parameter RATIO_W, default 8, meaning the width of the decimation-ratio field.
REQ-002 The block SHALL have parameter OUT_W, default 33, meaning the CIC output sample width.
REQ-003 The block SHALL have parameter CLR_CYC, default 2, meaning the number of cycles cic_clr is held.
REQ-004 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_ratio  in  RATIO_W  requested decimation ratio.
- cfg_settle  in  4  number of CIC outputs to discard after a clear.
- cfg_load  in  1  one-cycle pulse that latches cfg_ratio and cfg_settle and restarts the sequence.
- in_valid  in  1  DSM sample strobe, one per modulator sample.
- cic_valid  in  1  CIC output strobe.
- cic_data  in  OUT_W  signed CIC output.
- cic_clr  out  1  synchronous clear to the CIC integrators and combs.
- cic_dec_tick  out  1  decimation strobe to the CIC comb section.
- out_data  out  OUT_W  signed held sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- overrun  out  1  sticky flag: a sample was dropped.
- cfg_err  out  1  sticky flag: the latched ratio was below 2.
- busy  out  1  high in the CLEAR and SETTLE states.

Function
REQ-005 The FSM SHALL have four states: IDLE, CLEAR, SETTLE and RUN. Transitions:
- IDLE->CLEAR on cfg_load.
- CLEAR->SETTLE after CLR_CYC cycles.
- SETTLE->RUN once cfg_settle cic_valid pulses have been discarded; if cfg_settle=0, SETTLE lasts exactly 1 cycle.
- Any state->CLEAR on cfg_load, which restarts the clear count.
REQ-006 cic_clr SHALL be high during every cycle spent in CLEAR, and low otherwise.
REQ-007 A latched ratio of 0 or 1 SHALL be replaced by 2, and cfg_err SHALL be set.
REQ-008 The phase counter SHALL:
- reset to 0 in CLEAR;
- increment on each in_valid in SETTLE and RUN;
- wrap from ratio-1 to 0.
REQ-009 cic_dec_tick SHALL pulse for exactly one cycle, in the cycle after the in_valid that wraps the phase counter, so there is one tick per ratio samples.
REQ-010 in_valid SHALL be ignored in IDLE and CLEAR.
REQ-011 cic_valid pulses in SETTLE SHALL be counted and discarded; they never reach out_data.
REQ-012 In RUN, cic_valid SHALL load cic_data into out_data and set out_valid on the next cycle, giving 1-cycle latency.
REQ-013 out_valid SHALL be cleared in the cycle after a transfer where out_valid&&out_ready; out_data SHALL remain stable while out_valid&&!out_ready.
REQ-014 If cic_valid arrives while out_valid&&!out_ready, the new sample SHALL be dropped, the held sample kept, and overrun set.
REQ-015 If cic_valid coincides with an accepting out_ready, the new sample SHALL load and out_valid SHALL stay high, with no overrun.
REQ-016 cfg_load SHALL:
- clear overrun, cfg_err and out_valid;
- discard any held sample.
REQ-017 When cfg_load coincides with cic_valid, cfg_load SHALL win and the sample SHALL be discarded.
REQ-018 busy SHALL equal (state==CLEAR || state==SETTLE).

Reset
REQ-019 Assertion of rst (low) SHALL immediately force:
- state=IDLE;
- all counters to 0;
- latched ratio to 2 and latched settle to 0;
- all outputs to 0.
REQ-020 Reset release SHALL NOT start a sequence; only cfg_load does.

Configuration
REQ-021 When macro CIC_SEQ_STATS_EN is defined, the block SHALL add two 16-bit outputs:
- stat_out, which counts accepted transfers;
- stat_drop, which counts dropped samples.
Both SHALL saturate at 16'hFFFF and be cleared by reset or cfg_load.
REQ-022 Without CIC_SEQ_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then cfg_load with ratio=64, settle=3 -> cic_clr high for 2 cycles; first 3 cic_valid discarded; 4th appears on out_data 1 cycle later.
- Ratio=64 with in_valid every cycle for 640 cycles in RUN -> exactly 10 cic_dec_tick pulses, 64 cycles apart.
- out_ready=0 while 2 cic_valid pulses carry 100 then 200 -> out_data=100 and overrun=1; with CIC_SEQ_STATS_EN, stat_drop=1.
- cfg_load with ratio=1 -> cfg_err=1 and tick spacing 2; a second cfg_load with ratio=8 clears cfg_err.
- rst asserted mid-RUN with out_valid=1 -> out_valid=0 and state IDLE immediately; no tick until the next cfg_load.
- cfg_load in the same cycle as cic_valid during RUN -> no out_valid, and cic_clr asserts on the next cycle.
